// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO sitting between a UART receiver and a processor register read.
// Buffers received words, reports occupancy, and raises a sticky overflow flag
// when a word arrives while the buffer is full and nothing is being drained.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset,
  input  logic                       i_Rx_DV,
  input  logic [WIDTH-1:0]           i_Rx_Byte,
  input  logic                       i_Rd_En,
  input  logic                       i_Clr_Ovf,
  output logic [WIDTH-1:0]           o_Rd_Data,
  output logic                       o_Rd_Valid,
  output logic                       o_Empty,
  output logic                       o_Full,
  output logic [$clog2(DEPTH):0]     o_Level,
  output logic                       o_Overflow
);

  // Pointer width; DEPTH is a power of two so pointers wrap by natural rollover.
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] LvlDepth = LW'(DEPTH);
  localparam logic [LW-1:0] LvlOne   = LW'(1);

  // Storage and state
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_empty;
  logic             r_full;
  logic             r_overflow;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;

  // Decoded per-cycle events
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [LW-1:0]    w_level_next;

  // Decode accepted pop, accepted push and dropped word from current flags.
  always_comb begin
    w_pop  = i_Rd_En & ~r_empty;
    // A write into a full FIFO is still accepted when a pop frees a slot this cycle.
    w_push = i_Rx_DV & (~r_full | w_pop);
    w_drop = i_Rx_DV & r_full & ~w_pop;
  end

  // Next occupancy: +1 on push only, -1 on pop only, unchanged otherwise.
  always_comb begin
    w_level_next = r_level;
    unique case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + LvlOne;
      2'b01:   w_level_next = r_level - LvlOne;
      default: w_level_next = r_level;
    endcase
  end

  // Storage write; contents are not reset since pointers alone define validity.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset && w_push) begin
      r_mem[r_wr_ptr] <= i_Rx_Byte;
    end
  end

  // Pointers, occupancy and derived status flags, all registered together.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_level <= w_level_next;
      r_empty <= (w_level_next == '0);
      r_full  <= (w_level_next == LvlDepth);
    end
  end

  // Read data register holds the last popped word; valid pulses for one cycle per pop.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop) begin
        r_rd_data <= r_mem[r_rd_ptr];
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (i_Clr_Ovf) begin
      r_overflow <= 1'b0;
    end
  end

  assign o_Rd_Data  = r_rd_data;
  assign o_Rd_Valid = r_rd_valid;
  assign o_Empty    = r_empty;
  assign o_Full     = r_full;
  assign o_Level    = r_level;
  assign o_Overflow = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized bench for uart_rx_fifo against a queue-based model.
module tb_uart_rx_fifo;

  localparam int unsigned W = 16;
  localparam int unsigned D = 16;

  logic             clk;
  logic             rst;
  logic             dv;
  logic [W-1:0]     din;
  logic             rd;
  logic             clr;
  logic [W-1:0]     rd_data;
  logic             rd_valid;
  logic             empty;
  logic             full;
  logic [$clog2(D):0] level;
  logic             ovf;

  uart_rx_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_Rx_DV    (dv),
    .i_Rx_Byte  (din),
    .i_Rd_En    (rd),
    .i_Clr_Ovf  (clr),
    .o_Rd_Data  (rd_data),
    .o_Rd_Valid (rd_valid),
    .o_Empty    (empty),
    .o_Full     (full),
    .o_Level    (level),
    .o_Overflow (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ovf;

  int total;
  int bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare all outputs.
  task automatic step(input logic r, input logic v, input logic [W-1:0] d,
                      input logic p, input logic c, input string tag);
    bit do_pop, do_push, do_drop;
    rst = r; dv = v; din = d; rd = p; clr = c;
    @(posedge clk);
    #1;
    if (r) begin
      m_q.delete();
      m_data = '0; m_valid = 1'b0; m_ovf = 1'b0;
    end else begin
      do_pop  = p && (m_q.size() != 0);
      do_push = v && ((m_q.size() < D) || do_pop);
      do_drop = v && !do_push;
      m_valid = do_pop;
      if (do_pop) m_data = m_q.pop_front();
      if (do_push) m_q.push_back(d);
      if (do_drop) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
    end
    chk({tag, ".level"}, 32'(level), 32'(m_q.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(m_q.size() == 0));
    chk({tag, ".full"},  32'(full),  32'(m_q.size() == D));
    chk({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
    chk({tag, ".valid"}, 32'(rd_valid), 32'(m_valid));
    chk({tag, ".data"},  32'(rd_data),  32'(m_data));
    rst = 1'b0; dv = 1'b0; rd = 1'b0; clr = 1'b0;
  endtask

  task automatic wr(input logic [W-1:0] d, input string tag);
    step(1'b0, 1'b1, d, 1'b0, 1'b0, tag);
  endtask

  task automatic pop(input string tag);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    total = 0; bad = 0;
    m_data = '0; m_valid = 1'b0; m_ovf = 1'b0;
    rst = 1'b1; dv = 1'b0; din = '0; rd = 1'b0; clr = 1'b0;

    // Reset state, with other inputs active to show reset priority
    step(1'b1, 1'b1, 16'h7777, 1'b1, 1'b0, "rst0");
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, "rst1");

    // Three writes then three pops, first write on the cycle after reset
    wr(16'h1234, "b_wr0");
    wr(16'hABCD, "b_wr1");
    wr(16'h0001, "b_wr2");
    pop("b_pop0");
    pop("b_pop1");
    pop("b_pop2");
    idle("b_idle");
    pop("b_pop_empty");

    // Fill, overflow with 0xFFFF, drain 16
    for (int i = 0; i < 16; i++) wr(W'(i), "f_wr");
    wr(16'hFFFF, "f_drop");
    idle("f_hold");
    for (int i = 0; i < 16; i++) pop("f_pop");
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, "f_clr");

    // Full with simultaneous write and pop
    for (int i = 0; i < 16; i++) wr(W'(16'h0100 + i), "s_wr");
    step(1'b0, 1'b1, 16'h5555, 1'b1, 1'b0, "s_both");
    for (int i = 0; i < 16; i++) pop("s_pop");
    chk("s_last", 32'(rd_data), 32'h5555);

    // Empty with simultaneous write and read request: no fall-through
    step(1'b0, 1'b1, 16'h00AA, 1'b1, 1'b0, "e_both");
    pop("e_pop");
    chk("e_data", 32'(rd_data), 32'h00AA);

    // Random interleave, long enough for several pointer wraps
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0), "rnd");
    end
    while (m_q.size() != 0) pop("rnd_drain");

    // Load, overflow, reset mid-operation, stale data never returns
    for (int i = 0; i < 5; i++) wr(W'(16'h0A00 + i), "r_wr");
    for (int i = 5; i < 16; i++) wr(W'(16'h0A00 + i), "r_fill");
    wr(16'hDEAD, "r_drop");
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, "r_rst");
    pop("r_pop_ignored");
    idle("r_idle");

    // Drop coincident with clear: set wins, then a plain clear releases it
    for (int i = 0; i < 16; i++) wr(W'(16'h0B00 + i), "c_fill");
    step(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b1, "c_drop_clr");
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, "c_clr");
    for (int i = 0; i < 16; i++) pop("c_pop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
